// File: rtl/cpu_fetch_queue.sv
// Instruction fetch and pre-decode: fills a byte prefetch queue from 32-bit program RAM words
// and presents one complete 65C02 instruction (opcode plus 0-2 operands) per valid/ready handshake.
module cpu_fetch_queue #(
    parameter int QDEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_rd,
    output logic [13:0] o_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_opcode,
    output logic [15:0] o_operand,
    output logic [1:0]  o_length,
    output logic [15:0] o_pc,
    output logic [15:0] o_next_pc
);
    localparam int QW = 8 * QDEPTH;
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_reg, state_next;
    logic [QW-1:0] q_reg, q_next;
    logic [CW-1:0] count_reg, count_next;
    logic [15:0]   fetch_pc_reg, fetch_pc_next;
    logic [15:0]   head_pc_reg, head_pc_next;
    logic          inflight_reg, stale_reg;

    logic [1:0]    head_len;
    logic [15:0]   head_next_pc;
    logic          xfer, capture;
    logic [1:0]    lane_start;
    logic [CW-1:0] pop_len, app_len, base;
    logic [QW-1:0] q_shift, app_mask, app_data;

    function automatic logic [1:0] insn_length(input logic [7:0] op);
        logic [1:0] len;
        case (op[3:0])
            4'h3, 4'h8, 4'hA, 4'hB: len = 2'd1;
            4'hC, 4'hD, 4'hE, 4'hF: len = 2'd3;
            4'h9:                   len = op[4] ? 2'd3 : 2'd2;
            default:                len = 2'd2;
        endcase
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
        if (op == 8'h20) len = 2'd3;
        return len;
    endfunction

    // Byte 0 of the queue vector is always the instruction head.
    assign head_len     = insn_length(q_reg[7:0]);
    assign head_next_pc = head_pc_reg + 16'(head_len);

    assign o_valid = (state_reg == RUN) && (count_reg != '0) &&
                     (count_reg >= CW'(head_len)) && !i_redirect;

    // A stale read may still be returning; a new one can be issued alongside it.
    assign o_mem_rd   = (state_reg == RUN) && !(inflight_reg && !stale_reg) &&
                        (count_reg <= CW'(QDEPTH - 4));
    assign o_mem_addr = fetch_pc_reg[15:2];

    assign xfer       = o_valid && i_ready;
    assign capture    = inflight_reg && !stale_reg && !i_redirect;
    assign lane_start = fetch_pc_reg[1:0];
    assign pop_len    = xfer ? CW'(head_len) : '0;
    assign app_len    = capture ? CW'(3'd4 - {1'b0, lane_start}) : '0;
    assign base       = count_reg - pop_len;

    assign q_shift  = q_reg >> {pop_len, 3'b000};
    assign app_mask = QW'(32'hFFFF_FFFF >> {lane_start, 3'b000}) << {base, 3'b000};
    assign app_data = QW'(i_mem_data >> {lane_start, 3'b000}) << {base, 3'b000};

    assign o_opcode  = o_valid ? q_reg[7:0] : 8'h00;
    assign o_operand = o_valid ? {(head_len == 2'd3) ? q_reg[23:16] : 8'h00,
                                  (head_len != 2'd1) ? q_reg[15:8]  : 8'h00} : 16'h0000;
    assign o_length  = o_valid ? head_len : 2'd0;
    assign o_pc      = o_valid ? head_pc_reg : 16'h0000;
    assign o_next_pc = o_valid ? head_next_pc : 16'h0000;

    always_comb begin
        state_next    = state_reg;
        q_next        = q_reg;
        count_next    = count_reg;
        fetch_pc_next = fetch_pc_reg;
        head_pc_next  = head_pc_reg;
        if (i_redirect) begin
            state_next    = RUN;
            count_next    = '0;
            fetch_pc_next = i_redirect_pc;
            head_pc_next  = i_redirect_pc;
        end else if (state_reg == RUN) begin
            // Pop and append can coincide; the append lands just past the surviving bytes.
            q_next     = capture ? ((q_shift & ~app_mask) | app_data) : q_shift;
            count_next = count_reg - pop_len + app_len;
            if (capture) fetch_pc_next = {fetch_pc_reg[15:2] + 14'd1, 2'b00};
            if (xfer)    head_pc_next  = head_next_pc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            q_reg        <= '0;
            count_reg    <= '0;
            fetch_pc_reg <= 16'h0000;
            head_pc_reg  <= 16'h0000;
            inflight_reg <= 1'b0;
            stale_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            q_reg        <= q_next;
            count_reg    <= count_next;
            fetch_pc_reg <= fetch_pc_next;
            head_pc_reg  <= head_pc_next;
            // Every read returns exactly one edge after issue.
            inflight_reg <= o_mem_rd;
            stale_reg    <= o_mem_rd && i_redirect;
        end
    end
endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Bench for cpu_fetch_queue: byte-addressed RAM model, instruction-stream reference model
// with per-cycle compare, directed scenarios with literal expectations, then random traffic.
module tb_cpu_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic [13:0] mem_addr;
    logic [31:0] mem_data = 32'h0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  length;
    logic [15:0] pc;
    logic [15:0] next_pc;

    cpu_fetch_queue #(.QDEPTH(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_valid(valid), .i_ready(ready),
        .o_opcode(opcode), .o_operand(operand), .o_length(length),
        .o_pc(pc), .o_next_pc(next_pc)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];

    // RAM: one-cycle read latency; garbage on the bus when no read was issued.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= {mem[{mem_addr, 2'd3}], mem[{mem_addr, 2'd2}],
                                 mem[{mem_addr, 2'd1}], mem[{mem_addr, 2'd0}]};
        else        mem_data <= $urandom();
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 65C02 instruction length from the opcode byte.
    function automatic int mlen(input logic [7:0] op);
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
        if (op == 8'h20) return 3;
        if (op[3:0] == 4'h3 || op[3:0] == 4'h8 || op[3:0] == 4'hA || op[3:0] == 4'hB) return 1;
        if (op[3:0] >= 4'hC) return 3;
        if (op[3:0] == 4'h9 && op[4]) return 3;
        return 2;
    endfunction

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
        logic [15:0] pc;
        logic [15:0] npc;
    } xfer_t;
    xfer_t xlog[$];

    // Reference model: the instruction stream starting at the last redirect target.
    logic [15:0] exp_pc = 16'h0;
    logic [15:0] m_opnd, pc1, pc2;
    int m_len, age, exp_lat, gap;
    int first_age = -1;
    bit started = 0, pending = 0;

    always @(negedge clk) begin
        if (rst) begin
            started = 0; pending = 0; gap = 0;
        end else begin
            if (!started) begin
                check("idle_valid", 32'(valid), 0);
                check("idle_mem_rd", 32'(mem_rd), 0);
            end
            if (redirect) check("valid_during_redirect", 32'(valid), 0);
            m_len = 0;
            if (valid) begin
                pc1 = exp_pc + 16'd1;
                pc2 = exp_pc + 16'd2;
                m_len = mlen(mem[exp_pc]);
                m_opnd = 16'h0;
                if (m_len >= 2) m_opnd[7:0]  = mem[pc1];
                if (m_len == 3) m_opnd[15:8] = mem[pc2];
                check("opcode", 32'(opcode), 32'(mem[exp_pc]));
                check("operand", 32'(operand), 32'(m_opnd));
                check("length", 32'(length), 32'(m_len));
                check("pc", 32'(pc), 32'(exp_pc));
                check("next_pc", 32'(next_pc), 32'(16'(exp_pc + 16'(m_len))));
            end
            if (redirect) begin
                started = 1; pending = 1; age = -1; gap = 0; first_age = -1;
                exp_lat = ((4 - int'(redirect_pc[1:0])) >= mlen(mem[redirect_pc])) ? 2 : 4;
            end else if (pending) begin
                age++;
                if (valid && first_age < 0) first_age = age;
                if (age < exp_lat) check("valid_before_first_issue", 32'(valid), 0);
                else begin
                    check("valid_at_first_issue", 32'(valid), 1);
                    pending = 0;
                end
            end else if (started) begin
                if (valid) gap = 0;
                else gap++;
                if (gap > 10) begin
                    n_vec++; n_bad++;
                    $display("FAIL issue_progress: o_valid low for %0d cycles, limit 10", gap);
                    gap = 0;
                end
            end
            if (redirect) exp_pc = redirect_pc;
            else if (valid && ready) begin
                xlog.push_back('{opcode, operand, length, pc, next_pc});
                exp_pc = exp_pc + 16'(m_len);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] target, input logic rdy);
        ready = 1'b0;
        tick();
        xlog.delete();
        redirect = 1'b1;
        redirect_pc = target;
        ready = rdy;
        tick();
        redirect = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (xlog.size() < n && c < budget) begin
            tick();
            c++;
        end
        if (xlog.size() < n) begin
            n_vec++; n_bad++;
            $display("FAIL transfer_timeout: got %0d transfers, expected %0d", xlog.size(), n);
        end
    endtask

    task automatic expect_xfer(input int idx, input logic [7:0] op, input logic [15:0] opnd,
                               input logic [1:0] len, input logic [15:0] p, input logic [15:0] np);
        if (idx < xlog.size()) begin
            check($sformatf("xfer%0d_opcode", idx), 32'(xlog[idx].op), 32'(op));
            check($sformatf("xfer%0d_operand", idx), 32'(xlog[idx].opnd), 32'(opnd));
            check($sformatf("xfer%0d_length", idx), 32'(xlog[idx].len), 32'(len));
            check($sformatf("xfer%0d_pc", idx), 32'(xlog[idx].pc), 32'(p));
            check($sformatf("xfer%0d_next_pc", idx), 32'(xlog[idx].npc), 32'(np));
        end else begin
            n_vec++; n_bad++;
            $display("FAIL xfer%0d_missing: log has %0d entries", idx, xlog.size());
        end
    endtask

    task automatic check_stream_0200();
        expect_xfer(0, 8'hA9, 16'h0005, 2'd2, 16'h0200, 16'h0202);
        expect_xfer(1, 8'h8D, 16'h0300, 2'd3, 16'h0202, 16'h0205);
        expect_xfer(2, 8'hEA, 16'h0000, 2'd1, 16'h0205, 16'h0206);
        expect_xfer(3, 8'h4C, 16'h0200, 2'd3, 16'h0206, 16'h0209);
    endtask

    task automatic put_word(input logic [13:0] w, input logic [31:0] d);
        for (int b = 0; b < 4; b++) mem[{w, 2'(b)}] = d[8*b +: 8];
    endtask

    logic [7:0]  len_ops [8];
    logic [1:0]  len_exp [8];

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; ready = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom());
        put_word(14'h080, 32'h008D05A9);
        put_word(14'h081, 32'h004CEA03);
        put_word(14'h082, 32'h00000002);
        len_ops = '{8'h00, 8'hCB, 8'h80, 8'h89, 8'h07, 8'h99, 8'h5C, 8'h0F};
        len_exp = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
        begin
            logic [15:0] a = 16'h0300;
            for (int i = 0; i < 8; i++) begin
                mem[a] = len_ops[i];
                a = a + 16'(len_exp[i]);
            end
        end
        mem[16'h0400] = 8'hA2; mem[16'h0401] = 8'h42;
        mem[16'hFFFE] = 8'h20; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;

        repeat (3) tick();
        check("rst_valid", 32'(valid), 0);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_operand", 32'(operand), 0);
        check("rst_length", 32'(length), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_next_pc", 32'(next_pc), 0);
        rst = 1'b0;
        repeat (20) tick();

        // Aligned stream at 0x0200, core always ready.
        start(16'h0200, 1'b1);
        wait_log(4, 40);
        check("first_valid_age_0200", 32'(first_age), 2);
        check_stream_0200();

        // Same stream with the core stalled: queue fills and reads stop.
        start(16'h0200, 1'b0);
        repeat (12) tick();
        check("stall_mem_rd", 32'(mem_rd), 0);
        check("stall_valid", 32'(valid), 1);
        check("stall_pc", 32'(pc), 32'h0200);
        ready = 1'b1;
        wait_log(4, 40);
        check_stream_0200();

        // Misaligned redirect: the first word yields one byte only.
        mem[16'h0203] = 8'hA9; mem[16'h0204] = 8'h07;
        start(16'h0203, 1'b1);
        wait_log(1, 40);
        check("first_valid_age_0203", 32'(first_age), 4);
        expect_xfer(0, 8'hA9, 16'h0007, 2'd2, 16'h0203, 16'h0205);

        // Redirect while the 0x0200 word is in flight: that word must be dropped.
        start(16'h0200, 1'b1);
        check("read_issued_after_redirect", 32'(mem_rd), 1);
        check("read_addr_after_redirect", 32'(mem_addr), 32'h080);
        redirect = 1'b1; redirect_pc = 16'h0400;
        tick();
        redirect = 1'b0;
        wait_log(1, 40);
        check("first_valid_age_0400", 32'(first_age), 2);
        expect_xfer(0, 8'hA2, 16'h0042, 2'd2, 16'h0400, 16'h0402);

        // Wrap across the top of the address space.
        start(16'hFFFE, 1'b1);
        wait_log(1, 40);
        check("first_valid_age_fffe", 32'(first_age), 4);
        expect_xfer(0, 8'h20, 16'h1234, 2'd3, 16'hFFFE, 16'h0001);

        // Length decode spot checks.
        start(16'h0300, 1'b1);
        wait_log(8, 80);
        for (int i = 0; i < 8; i++)
            if (i < xlog.size())
                check($sformatf("len_op_%0h", len_ops[i]), 32'(xlog[i].len), 32'(len_exp[i]));

        // Random traffic, with one mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 39) == 0);
            redirect_pc = 16'($urandom());
            if (i == 1500) begin
                redirect = 1'b0;
                rst = 1'b1;
                #1;
                check("midrun_rst_valid", 32'(valid), 0);
                check("midrun_rst_mem_rd", 32'(mem_rd), 0);
                check("midrun_rst_pc", 32'(pc), 0);
                tick(); tick();
                rst = 1'b0;
                repeat (5) tick();
                redirect = 1'b1;
            end
            tick();
        end
        redirect = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
